// File: rtl/multdiv_ctrl.sv
// Sequencer for the multicycle multiply/divide datapath: runs CYCLES iteration
// enables per op, holds the result for writeback, and raises RAW hazard/stall.
module multdiv_ctrl #(
    parameter int CYCLES = 32,
    parameter int CNT_W  = 6
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             start_mult,
    input  logic             start_div,
    input  logic [4:0]       rd_in,
    input  logic [4:0]       rs,
    input  logic [4:0]       rt,
    input  logic             wb_ack,
    output logic             busy,
    output logic             iter_en,
    output logic             first_iter,
    output logic             op_is_div,
    output logic [CNT_W-1:0] count,
    output logic [4:0]       pending_rd,
    output logic             result_valid,
    output logic             hazard,
    output logic             stall
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    localparam logic [CNT_W-1:0] LAST = CNT_W'(CYCLES - 1);

    logic [1:0] state;
    logic       start;
    logic       ack_done;

    assign start    = start_mult | start_div;
    assign ack_done = (state == DONE) & wb_ack;

    // Result handshake: result_valid is held in DONE until the cycle wb_ack is
    // high; that edge consumes it. wb_ack in any other state has no effect.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state      <= IDLE;
            count      <= '0;
            pending_rd <= '0;
            op_is_div  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        pending_rd <= rd_in;
                        op_is_div  <= start_div;
                        count      <= '0;
                        state      <= RUN;
                    end
                end
                RUN: begin
                    if (count == LAST) begin
                        state <= DONE;
                    end else begin
                        count <= count + CNT_W'(1);
                    end
                end
                DONE: begin
                    if (wb_ack) begin
                        count <= '0;
                        // A start on the ack edge chains straight into the next op.
                        if (start) begin
                            pending_rd <= rd_in;
                            op_is_div  <= start_div;
                            state      <= RUN;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign busy         = (state != IDLE);
    assign iter_en      = (state == RUN);
    assign first_iter   = (state == RUN) & (count == '0);
    assign result_valid = (state == DONE);

    // Register 0 is hardwired, so it never carries a dependency.
    assign hazard = busy & (pending_rd != 5'd0) &
                    ((rs == pending_rd) | (rt == pending_rd));
    assign stall  = hazard | (start & busy & ~ack_done);

endmodule

// File: doc/multdiv_ctrl.md
Name: multdiv_ctrl

Overview:
Sequencer for the multicycle multiply/divide datapath. Accepts a start from decode, captures the 5-bit destination register number, and drives one iteration enable per cycle for CYCLES cycles. It then holds the result until writeback acknowledges it. While the op is outstanding it flags RAW hazards on the pending destination and generates the pipeline stall.

Parameters:
CYCLES, 32, iterations per operation (legal range 2..63)
CNT_W, 6, iteration counter width (must satisfy 2^CNT_W > CYCLES)

Ports:
clk  input  1  system clock, rising edge
clr  input  1  asynchronous, active-low reset (0 = reset)
start_mult  input  1  decode requests a multiply, one-cycle qualifier
start_div  input  1  decode requests a divide, one-cycle qualifier
rd_in  input  5  destination register of the requesting instruction
rs  input  5  source register A of the instruction in decode
rt  input  5  source register B of the instruction in decode
wb_ack  input  1  writeback has consumed the result
busy  output  1  state != IDLE
iter_en  output  1  datapath iteration enable (RUN only)
first_iter  output  1  high on the first RUN cycle only; datapath loads its operands
op_is_div  output  1  latched op type: 1 = divide, 0 = multiply
count  output  CNT_W  current iteration index
pending_rd  output  5  latched destination register
result_valid  output  1  result ready for writeback (DONE)
hazard  output  1  decode source matches the outstanding destination
stall  output  1  freeze fetch/decode

Behaviour:
- Reset (clr=0, asynchronous): state goes to IDLE immediately; count, pending_rd and op_is_div are cleared to 0; all outputs read 0. Reset asserted mid-RUN or in DONE aborts the op with no result_valid pulse.
- start = start_mult | start_div. If both are high, divide wins: op_is_div is set to 1.
- IDLE:
  - On a clock edge with start=1: pending_rd <= rd_in, op_is_div <= start_div, count <= 0, next state RUN.
  - Otherwise the state stays IDLE.
- RUN:
  - iter_en=1 every cycle.
  - first_iter=1 only while count==0.
  - Each edge: if count==CYCLES-1, next state DONE and count holds; otherwise count <= count+1.
  - iter_en is high for exactly CYCLES cycles.
  - Start asserted during RUN is not accepted, and no register changes.
- DONE:
  - result_valid=1 and held until wb_ack=1.
  - On the edge with wb_ack=1 and start=0: next state IDLE, count <= 0.
  - On the edge with wb_ack=1 and start=1 (back-to-back): capture the new rd_in and op, count <= 0, next state RUN.
  - wb_ack outside DONE is ignored.
- Latency: start accepted at edge E0 gives result_valid from the cycle after edge E(CYCLES) onward.
- hazard (combinational) = busy & (pending_rd != 0) & ((rs == pending_rd) | (rt == pending_rd)). Register 0 never creates a hazard. An op with rd_in=0 still runs and still raises result_valid.
- stall (combinational) = hazard | (start & busy & ~(DONE & wb_ack)).
  - In the back-to-back case stall stays 0, because the new start is accepted.
- count and pending_rd remain stable whenever their update condition is false.
- All state updates are on the rising clk edge, except the asynchronous reset.

Test Plan:
- Reset, then start_mult=1, rd_in=5'd7 at edge E0 -> busy=1, op_is_div=0, pending_rd=7, first_iter=1 for one cycle, iter_en high exactly 32 cycles with count stepping 0..31, result_valid=1 after E32; wb_ack=1 -> IDLE, busy=0.
- During RUN with pending_rd=7: rs=7 -> hazard=1, stall=1; rt=7 -> hazard=1, stall=1; rs=rt=3 -> hazard=0; rd_in=0 op with rs=0 -> hazard=0 throughout.
- start_mult and start_div both high, rd_in=12 -> op_is_div=1, pending_rd=12; start_mult pulsed at count=10 -> stall=1, pending_rd stays 12, count continues to 11.
- In DONE: hold wb_ack=0 for 5 cycles -> result_valid stays 1; then wb_ack=1 with start_div=1, rd_in=9 -> stall=0, next cycle RUN with count=0, op_is_div=1, pending_rd=9, first_iter=1.
- Drive clr=0 mid-RUN at count=15, between clock edges -> busy, iter_en, count and pending_rd all read 0 before the next edge; release clr -> controller stays IDLE until a new start.
- With CYCLES=2 -> iter_en high exactly 2 cycles and result_valid asserted after E2.
